fetch_queue: RTL and testbench

Instruction fetch stage that sits directly upstream of the single-cycle datapath's decode/control logic. It owns the program counter, issues word reads to instruction memory over a req/ack handshake, buffers returned instructions with their PC in a small FIFO, and presents them to decode with valid/ready. A redirect input from branch/jump resolution flushes the queue and restarts fetch, correctly discarding any abandoned in-flight read.

---
 rtl/fetch_queue.sv | 206 ++++++++++++++++++++
 tb/tb_fetch_queue.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch stage feeding decode.
// Owns the program counter, issues one word read at a time over a req/ack
// handshake, buffers {instruction, pc} pairs in a small FIFO and hands them
// to decode with valid/ready. A redirect flushes the queue and restarts
// fetch; a read that was already in flight is drained and its data dropped.
// Optional build macro: FETCH_PERF_EN enables the stall/flush counters;
// without it both counter ports are tied to zero.
module fetch_queue #(
  parameter int            AW       = 5,
  parameter int            DEPTH    = 4,
  parameter logic [AW-1:0] RESET_PC = {AW{1'b0}}
) (
  input  logic          clk,
  input  logic          reset,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [31:0]   imem_rdata,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_pc,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_instr,
  output logic [AW-1:0] out_pc,
  output logic [15:0]   perf_stall_cnt,
  output logic [15:0]   perf_flush_cnt
);

  localparam int            PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int            CW      = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  state_t        state_r, state_nxt_s;
  // In DRAIN, fetch_pc_r keeps the abandoned address so imem_addr stays
  // stable until the memory acks; the real restart address sits in drain_pc_r.
  logic [AW-1:0] fetch_pc_r, fetch_pc_nxt_s;
  logic [AW-1:0] drain_pc_r, drain_pc_nxt_s;
  logic [CW-1:0] count_r, count_nxt_s;
  logic [PW-1:0] wr_ptr_r, wr_ptr_nxt_s;
  logic [PW-1:0] rd_ptr_r, rd_ptr_nxt_s;
  logic [31:0]   instr_mem_r [DEPTH];
  logic [AW-1:0] pc_mem_r    [DEPTH];

  logic req_s;
  logic xfer_s;
  logic push_s;
  logic pop_s;
  logic valid_s;

  // Request and handshake qualifiers; the request depends only on state, never on out_ready.
  always_comb begin
    req_s = 1'b0;
    if (state_r == ST_DRAIN) begin
      req_s = 1'b1;
    end else if (count_r < DEPTH_C) begin
      req_s = 1'b1;
    end else begin
      req_s = 1'b0;
    end
    valid_s = (count_r != {CW{1'b0}});
    xfer_s  = req_s && imem_ack;
    push_s  = xfer_s && (state_r == ST_RUN) && !redirect;
    pop_s   = valid_s && out_ready;
  end

  assign imem_req  = reset && req_s;
  assign imem_addr = fetch_pc_r;
  assign out_valid = valid_s;
  assign out_instr = valid_s ? instr_mem_r[rd_ptr_r] : 32'h0000_0000;
  assign out_pc    = valid_s ? pc_mem_r[rd_ptr_r]    : {AW{1'b0}};

  // Next-state for the fetch FSM, program counter and queue bookkeeping.
  always_comb begin
    state_nxt_s    = state_r;
    fetch_pc_nxt_s = fetch_pc_r;
    drain_pc_nxt_s = drain_pc_r;
    count_nxt_s    = count_r;
    wr_ptr_nxt_s   = wr_ptr_r;
    rd_ptr_nxt_s   = rd_ptr_r;

    case (state_r)
      ST_RUN: begin
        if (redirect) begin
          if (req_s && !imem_ack) begin
            // Read in flight: wait for it, then restart at the new address.
            state_nxt_s    = ST_DRAIN;
            drain_pc_nxt_s = redirect_pc;
          end else begin
            // Idle or completing this cycle: data (if any) is dropped.
            fetch_pc_nxt_s = redirect_pc;
          end
        end else if (xfer_s) begin
          fetch_pc_nxt_s = fetch_pc_r + AW'(1);
        end else begin
          fetch_pc_nxt_s = fetch_pc_r;
        end
      end
      ST_DRAIN: begin
        if (imem_ack) begin
          state_nxt_s    = ST_RUN;
          fetch_pc_nxt_s = redirect ? redirect_pc : drain_pc_r;
        end else if (redirect) begin
          drain_pc_nxt_s = redirect_pc;
        end else begin
          drain_pc_nxt_s = drain_pc_r;
        end
      end
      default: begin
        state_nxt_s = ST_RUN;
      end
    endcase

    if (redirect) begin
      count_nxt_s  = {CW{1'b0}};
      wr_ptr_nxt_s = {PW{1'b0}};
      rd_ptr_nxt_s = {PW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_nxt_s = wr_ptr_r + PW'(1);
      end else begin
        wr_ptr_nxt_s = wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_nxt_s = rd_ptr_r + PW'(1);
      end else begin
        rd_ptr_nxt_s = rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_nxt_s = count_r + CW'(1);
        2'b01:   count_nxt_s = count_r - CW'(1);
        default: count_nxt_s = count_r;
      endcase
    end
  end

  // State, program counter and queue pointer registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= ST_RUN;
      fetch_pc_r <= RESET_PC;
      drain_pc_r <= {AW{1'b0}};
      count_r    <= {CW{1'b0}};
      wr_ptr_r   <= {PW{1'b0}};
      rd_ptr_r   <= {PW{1'b0}};
    end else begin
      state_r    <= state_nxt_s;
      fetch_pc_r <= fetch_pc_nxt_s;
      drain_pc_r <= drain_pc_nxt_s;
      count_r    <= count_nxt_s;
      wr_ptr_r   <= wr_ptr_nxt_s;
      rd_ptr_r   <= rd_ptr_nxt_s;
    end
  end

  // Queue storage: capture the returned word together with the pc it was fetched from.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem_r[i] <= 32'h0000_0000;
        pc_mem_r[i]    <= {AW{1'b0}};
      end
    end else if (push_s) begin
      instr_mem_r[wr_ptr_r] <= imem_rdata;
      pc_mem_r[wr_ptr_r]    <= fetch_pc_r;
    end else begin
      instr_mem_r[wr_ptr_r] <= instr_mem_r[wr_ptr_r];
      pc_mem_r[wr_ptr_r]    <= pc_mem_r[wr_ptr_r];
    end
  end

`ifdef FETCH_PERF_EN
  logic [15:0] stall_cnt_r;
  logic [15:0] flush_cnt_r;

  // Saturating counters: decode-starved cycles and redirects taken.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_r <= 16'h0000;
      flush_cnt_r <= 16'h0000;
    end else begin
      if (!valid_s && out_ready && (stall_cnt_r != 16'hFFFF)) begin
        stall_cnt_r <= stall_cnt_r + 16'h0001;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (redirect && (flush_cnt_r != 16'hFFFF)) begin
        flush_cnt_r <= flush_cnt_r + 16'h0001;
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

  assign perf_stall_cnt = stall_cnt_r;
  assign perf_flush_cnt = flush_cnt_r;
`else
  assign perf_stall_cnt = 16'h0000;
  assign perf_flush_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: scoreboard bench for fetch_queue (AW=5, DEPTH=4, RESET_PC=0).
// A reference model tracks the expected fetch address and queue contents;
// words are pushed to the scoreboard when the memory transfer is driven and
// popped/compared when decode accepts them.
module tb_fetch_queue;
  localparam int AW    = 5;
  localparam int DEPTH = 4;
`ifdef FETCH_PERF_EN
  localparam logic PERF_EN = 1'b1;
`else
  localparam logic PERF_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack;
  logic [31:0]   imem_rdata;
  logic          redirect;
  logic [AW-1:0] redirect_pc;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_instr;
  logic [AW-1:0] out_pc;
  logic [15:0]   perf_stall_cnt;
  logic [15:0]   perf_flush_cnt;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [31:0]   instr;
    logic [AW-1:0] pc;
  } entry_t;

  entry_t        sb_q[$];
  logic          m_drain;
  logic [AW-1:0] m_pc;
  logic [AW-1:0] m_drain_pc;
  logic [15:0]   m_stall;
  logic [15:0]   m_flush;
  logic [AW-1:0] held_addr;

  fetch_queue #(.AW(AW), .DEPTH(DEPTH), .RESET_PC(5'd0)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
    return {8'hA5, 3'b000, a, 8'h3C, a, 3'b101};
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for out_valid, checking at mid-cycle; caller is at +3 of a cycle.
  task automatic wait_valid(input string tag);
    int n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      step();
      #2;
      n++;
    end
    check_eq(tag, {63'd0, out_valid}, 64'd1);
  endtask

  // Reference model and scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    logic   exp_req;
    entry_t e;
    if (!reset) begin
      sb_q.delete();
      m_drain    = 1'b0;
      m_pc       = 5'd0;
      m_drain_pc = 5'd0;
      m_stall    = 16'd0;
      m_flush    = 16'd0;
      check_eq("rst_req", {63'd0, imem_req}, 64'd0);
      check_eq("rst_valid", {63'd0, out_valid}, 64'd0);
      check_eq("rst_instr", {32'd0, out_instr}, 64'd0);
      check_eq("rst_pc", {59'd0, out_pc}, 64'd0);
      check_eq("rst_stall", {48'd0, perf_stall_cnt}, 64'd0);
      check_eq("rst_flush", {48'd0, perf_flush_cnt}, 64'd0);
    end else begin
      check_eq("perf_stall", {48'd0, perf_stall_cnt}, {48'd0, (PERF_EN ? m_stall : 16'd0)});
      check_eq("perf_flush", {48'd0, perf_flush_cnt}, {48'd0, (PERF_EN ? m_flush : 16'd0)});
      exp_req = m_drain || (sb_q.size() < DEPTH);
      check_eq("imem_req", {63'd0, imem_req}, {63'd0, exp_req});
      if (exp_req) begin
        check_eq("imem_addr", {59'd0, imem_addr}, {59'd0, m_pc});
      end
      check_eq("out_valid", {63'd0, out_valid}, {63'd0, (sb_q.size() != 0)});
      if (sb_q.size() != 0) begin
        check_eq("out_pc", {59'd0, out_pc}, {59'd0, sb_q[0].pc});
        check_eq("out_instr", {32'd0, out_instr}, {32'd0, sb_q[0].instr});
      end else begin
        check_eq("out_pc_idle", {59'd0, out_pc}, 64'd0);
        check_eq("out_instr_idle", {32'd0, out_instr}, 64'd0);
      end
      // Model update for the coming clock edge.
      if (sb_q.size() == 0 && out_ready && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
      if (sb_q.size() != 0 && out_ready) void'(sb_q.pop_front());
      if (redirect && m_flush != 16'hFFFF) m_flush = m_flush + 16'd1;
      if (exp_req && imem_ack) begin
        if (m_drain) begin
          m_drain = 1'b0;
          m_pc    = redirect ? redirect_pc : m_drain_pc;
        end else if (redirect) begin
          m_pc = redirect_pc;
        end else begin
          e.instr = mem_word(m_pc);
          e.pc    = m_pc;
          sb_q.push_back(e);
          m_pc = m_pc + 5'd1;
        end
      end else if (redirect) begin
        if (m_drain) begin
          m_drain_pc = redirect_pc;
        end else if (exp_req) begin
          m_drain    = 1'b1;
          m_drain_pc = redirect_pc;
        end else begin
          m_pc = redirect_pc;
        end
      end
      if (redirect) sb_q.delete();
    end
  end

  initial begin
    reset       = 1'b0;
    imem_ack    = 1'b1;
    out_ready   = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 5'd0;
    repeat (3) step();
    reset = 1'b1;

    // Streaming: one instruction per cycle, addresses wrap 31 -> 0.
    repeat (40) step();

    // Decode stalls: queue fills, request drops; resumes one cycle after first pop.
    out_ready = 1'b0;
    repeat (10) step();
    #2;
    check_eq("full_req_low", {63'd0, imem_req}, 64'd0);
    check_eq("full_valid", {63'd0, out_valid}, 64'd1);
    out_ready = 1'b1;
    #1;
    check_eq("full_pop_cycle_req", {63'd0, imem_req}, 64'd0);
    step();
    #2;
    check_eq("full_req_back", {63'd0, imem_req}, 64'd1);

    // Explicit wrap: restart at 30, expect 30, 31, 0 back to back.
    redirect = 1'b1;
    redirect_pc = 5'd30;
    step();
    redirect = 1'b0;
    #2;
    check_eq("wrap_flush_valid", {63'd0, out_valid}, 64'd0);
    wait_valid("wrap_seen");
    check_eq("wrap_pc30", {59'd0, out_pc}, 64'd30);
    step();
    #2;
    check_eq("wrap_pc31", {59'd0, out_pc}, 64'd31);
    step();
    #2;
    check_eq("wrap_pc0", {59'd0, out_pc}, 64'd0);

    // Redirect to 12 with three entries queued and a transfer completing.
    out_ready = 1'b0;
    redirect = 1'b1;
    redirect_pc = 5'd5;
    step();
    redirect = 1'b0;
    repeat (3) step();
    #2;
    check_eq("three_queued_head", {59'd0, out_pc}, 64'd5);
    redirect = 1'b1;
    redirect_pc = 5'd12;
    step();
    redirect = 1'b0;
    #2;
    check_eq("redir12_valid", {63'd0, out_valid}, 64'd0);
    out_ready = 1'b1;
    wait_valid("redir12_seen");
    check_eq("redir12_pc", {59'd0, out_pc}, 64'd12);

    // Pending read abandoned: redirect to 20, then 25 while draining.
    imem_ack = 1'b0;
    held_addr = imem_addr;
    redirect = 1'b1;
    redirect_pc = 5'd20;
    step();
    redirect_pc = 5'd25;
    #2;
    check_eq("drain_req", {63'd0, imem_req}, 64'd1);
    check_eq("drain_addr1", {59'd0, imem_addr}, {59'd0, held_addr});
    check_eq("drain_valid", {63'd0, out_valid}, 64'd0);
    step();
    redirect = 1'b0;
    #2;
    check_eq("drain_addr2", {59'd0, imem_addr}, {59'd0, held_addr});
    imem_ack = 1'b1;
    step();
    #2;
    check_eq("drain_next_addr", {59'd0, imem_addr}, 64'd25);
    wait_valid("drain_seen");
    check_eq("drain_first_pc", {59'd0, out_pc}, 64'd25);

    // Reset in the middle of an outstanding request.
    imem_ack = 1'b0;
    step();
    #2;
    reset = 1'b0;
    #1;
    check_eq("midrst_req", {63'd0, imem_req}, 64'd0);
    check_eq("midrst_valid", {63'd0, out_valid}, 64'd0);
    step();

    // Performance counters: five starved cycles and two redirects.
    reset = 1'b1;
    repeat (5) step();
    redirect = 1'b1;
    redirect_pc = 5'd7;
    step();
    redirect_pc = 5'd9;
    step();
    redirect = 1'b0;
    imem_ack = 1'b1;
    repeat (6) step();
    #2;
    check_eq("perf_flush_two", {48'd0, perf_flush_cnt}, {48'd0, (PERF_EN ? 16'd2 : 16'd0)});
    check_eq("perf_stall_min", {63'd0, (perf_stall_cnt >= 16'd5)}, {63'd0, PERF_EN});

    // Random mix of ack, ready and redirect.
    for (int i = 0; i < 300; i++) begin
      imem_ack    = ($urandom_range(0, 3) != 0);
      out_ready   = ($urandom_range(0, 3) != 0);
      redirect    = ($urandom_range(0, 15) == 0);
      redirect_pc = AW'($urandom_range(0, 31));
      step();
    end
    redirect = 1'b0;
    imem_ack = 1'b1;
    out_ready = 1'b1;
    repeat (10) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
